alu_arbiter: RTL and testbench

Shares one ALU instance between NUM_REQ requesters, e.g. the core execute stage and a debug or CSR helper.
- Accepts one operation at a time with round-robin fairness.
- Registers the operands, evaluates them on the ALU, and returns the registered result to the winning requester over a valid/ready response channel.
- Owns the ALU instance internally.

---
 rtl/alu_arbiter_pkg.sv | 35 +++
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu_arbiter_alu.sv | 43 ++++
 rtl/alu_arbiter_rr_picker.sv | 43 ++++
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 6 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared types and constants for the ALU arbiter slice:
//   alu_op_t    - one ALU operation as presented by a requester
//   arb_state_t - arbiter sequencing states
//   ALU_XLEN    - datapath width
//   wrap_add    - modular index helper used by the round-robin picker
package alu_arbiter_pkg;

    localparam int ALU_XLEN = 32;

    typedef struct packed {
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                opImm;
        logic [ALU_XLEN-1:0] rs1;
        logic [ALU_XLEN-1:0] rs2;
        logic [ALU_XLEN-1:0] immediateI;
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    // (base + off) mod n for 0 <= base < n and 0 < off <= n; a single
    // conditional subtract avoids a general modulo.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Request/response bundle between NUM_REQ requesters and the arbiter.
//   req_valid/req_ready/req_op/req_tag   - per-requester request channel
//   resp_valid/resp_ready                - per-requester response handshake
//   resp_result/resp_tag                 - shared response payload
//   req_lock/lock_owner_valid            - only when ALU_ARB_LOCK_EN is defined
// Modports: master (requester side), slave (arbiter side).
interface alu_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int TAG_WIDTH = 4
) ();
    import alu_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    alu_op_t [NUM_REQ-1:0]             req_op;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0] req_tag;
    logic [NUM_REQ-1:0]                resp_valid;
    logic [NUM_REQ-1:0]                resp_ready;
    logic [ALU_XLEN-1:0]               resp_result;
    logic [TAG_WIDTH-1:0]              resp_tag;

`ifdef ALU_ARB_LOCK_EN
    logic [NUM_REQ-1:0]                req_lock;
    logic                              lock_owner_valid;

    modport master (
        output req_valid, req_op, req_tag, resp_ready, req_lock,
        input  req_ready, resp_valid, resp_result, resp_tag, lock_owner_valid
    );
    modport slave (
        input  req_valid, req_op, req_tag, resp_ready, req_lock,
        output req_ready, resp_valid, resp_result, resp_tag, lock_owner_valid
    );
`else
    modport master (
        output req_valid, req_op, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag
    );
    modport slave (
        input  req_valid, req_op, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag
    );
`endif

endinterface

// File: rtl/alu_arbiter_alu.sv
// alu
// RV32I integer ALU (combinational).
//   funct3_i, funct7_i, op_imm_i - operation select
//   rs1_i, rs2_i, imm_i          - operands; imm_i replaces rs2_i when op_imm_i
//   result_o                     - result
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]          funct3_i,
    input  logic [6:0]          funct7_i,
    input  logic                op_imm_i,
    input  logic [ALU_XLEN-1:0] rs1_i,
    input  logic [ALU_XLEN-1:0] rs2_i,
    input  logic [ALU_XLEN-1:0] imm_i,
    output logic [ALU_XLEN-1:0] result_o
);

    logic [ALU_XLEN-1:0] operand2;
    logic [4:0]          shamt;
    logic                unused_bits;

    assign operand2    = op_imm_i ? imm_i : rs2_i;
    assign shamt       = operand2[4:0];
    assign unused_bits = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        result_o = '0;
        case (funct3_i)
            // Immediate form has no subtract: addi ignores funct7[5].
            3'b000: result_o = (funct7_i[5] && !op_imm_i) ? rs1_i - operand2
                                                          : rs1_i + operand2;
            3'b001: result_o = rs1_i << shamt;
            3'b010: result_o = {{(ALU_XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(operand2))};
            3'b011: result_o = {{(ALU_XLEN-1){1'b0}}, (rs1_i < operand2)};
            3'b100: result_o = rs1_i ^ operand2;
            3'b101: result_o = funct7_i[5] ? ALU_XLEN'($signed(rs1_i) >>> shamt)
                                           : rs1_i >> shamt;
            3'b110: result_o = rs1_i | operand2;
            default: result_o = rs1_i & operand2;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector. The search starts one past ptr_i and
// wraps modulo NUM_REQ; the first asserted request wins.
//   req_i   - request vector
//   ptr_i   - index of the previous winner
//   grant_o - one-hot grant (zero when no request)
//   idx_o   - index of the winner
//   valid_o - any request present
module rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // cand_idx[k] is the requester examined at search position k.
    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = IDX_W'(wrap_add(int'(ptr_i), gi + 1, NUM_REQ));
    end

    // Scanning from the far end lets the nearest candidate overwrite.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[cand_idx[k]]) begin
                idx_o   = cand_idx[k];
                valid_o = 1'b1;
            end
        end
        if (valid_o) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between NUM_REQ requesters. One operation is in flight at a
// time: IDLE (grant) -> EXEC (evaluate, register result) -> RESP (hold result
// until the owner accepts it). Winner selection is round robin.
// Ports:
//   clock   - system clock
//   reset_n - synchronous active-low reset
//   bus     - alu_arbiter_if.slave request/response bundle
//   busy    - high while an op is in EXEC or RESP
// Optional: define ALU_ARB_LOCK_EN to add req_lock/lock_owner_valid, letting
// the owner keep the ALU across back-to-back ops.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    alu_arbiter_if.slave bus,
    output logic         busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    alu_op_t             op_q, op_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [ALU_XLEN-1:0] result_q, result_d;

    logic [NUM_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_valid;
    logic [IDX_W-1:0]    win_idx;
    logic                win_valid;
    logic [ALU_XLEN-1:0] alu_result;
    logic                unused_grant;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (last_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    // The one-hot form is rebuilt below with the lock override applied.
    assign unused_grant = ^rr_grant;

    alu u_alu (
        .funct3_i (op_q.funct3),
        .funct7_i (op_q.funct7),
        .op_imm_i (op_q.opImm),
        .rs1_i    (op_q.rs1),
        .rs2_i    (op_q.rs2),
        .imm_i    (op_q.immediateI),
        .result_o (alu_result)
    );

`ifdef ALU_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_hold;

    // A locked owner that is requesting again wins outright.
    assign lock_hold            = lock_q && bus.req_valid[grant_q];
    assign win_idx              = lock_hold ? grant_q : rr_idx;
    assign win_valid            = lock_hold || rr_valid;
    assign bus.lock_owner_valid = lock_q;
`else
    assign win_idx   = rr_idx;
    assign win_valid = rr_valid;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hs
        assign bus.req_ready[gi]  = reset_n && (state_q == IDLE) && win_valid
                                    && (win_idx == IDX_W'(gi));
        assign bus.resp_valid[gi] = reset_n && (state_q == RESP)
                                    && (grant_q == IDX_W'(gi));
    end

    assign bus.resp_result = result_q;
    assign bus.resp_tag    = tag_q;
    assign busy            = reset_n && (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        op_d     = op_q;
        tag_d    = tag_q;
        result_d = result_q;
`ifdef ALU_ARB_LOCK_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ALU_ARB_LOCK_EN
                // Owner went quiet: give up the lock and arbitrate normally.
                if (lock_q && !lock_hold) lock_d = 1'b0;
`endif
                if (win_valid) begin
                    state_d = EXEC;
                    last_d  = win_idx;
                    grant_d = win_idx;
                    op_d    = bus.req_op[win_idx];
                    tag_d   = bus.req_tag[win_idx];
                end
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.resp_ready[grant_q]) begin
                    state_d = IDLE;
`ifdef ALU_ARB_LOCK_EN
                    lock_d  = bus.req_lock[grant_q];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            result_q <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            result_q <= result_d;
`ifdef ALU_ARB_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter with two requesters. Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int TW = 4;

    logic clock;
    logic reset_n;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_arbiter_if #(.NUM_REQ(NR), .TAG_WIDTH(TW)) bus ();

    alu_arbiter #(.NUM_REQ(NR), .TAG_WIDTH(TW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic alu_op_t mk(input logic [2:0] f3, input logic [6:0] f7, input logic imm_sel,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        alu_op_t o;
        o.funct3     = f3;
        o.funct7     = f7;
        o.opImm      = imm_sel;
        o.rs1        = a;
        o.rs2        = b;
        o.immediateI = imm;
        return o;
    endfunction

    // Holds reset over two rising edges and checks the reset outputs.
    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.resp_ready = '1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst.req_ready",   bus.req_ready, 0);
        chk("rst.resp_valid",  bus.resp_valid, 0);
        chk("rst.busy",        busy, 0);
        chk("rst.resp_result", bus.resp_result, 0);
        chk("rst.resp_tag",    bus.resp_tag, 0);
        reset_n = 1'b1;
    endtask

    // One complete op: grant at cycle N, EXEC at N+1, response at N+2.
    // Returns in the RESP low phase; resp_ready is high so the op retires
    // at the following rising edge.
    task automatic do_op(input int idx, input logic [NR-1:0] vmask,
                         input logic [31:0] exp_res, input logic [TW-1:0] exp_tag,
                         input string name);
        logic [NR-1:0] oh;
        oh = NR'(1) << idx;
        @(negedge clock);
        bus.req_valid = vmask;
        #1;
        chk({name, ".grant"}, bus.req_ready, oh);
        @(negedge clock);
        #1;
        chk({name, ".exec_busy"},  busy, 1);
        chk({name, ".exec_ready"}, bus.req_ready, 0);
        chk({name, ".exec_rv"},    bus.resp_valid, 0);
        @(negedge clock);
        #1;
        chk({name, ".resp_valid"},  bus.resp_valid, oh);
        chk({name, ".resp_result"}, bus.resp_result, exp_res);
        chk({name, ".resp_tag"},    bus.resp_tag, exp_tag);
        $display("txn %s: req%0d tag 0x%0h result 0x%08h", name, idx, bus.resp_tag, bus.resp_result);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        bus.req_op     = '0;
        bus.req_tag    = '0;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock   = '0;
`endif
        do_reset();

        // Single add and opImm edge cases on requester 0.
        bus.req_op[0] = mk(3'b000, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0);
        bus.req_tag[0] = 4'h3;
        do_op(0, 2'b01, 32'd12, 4'h3, "add");
        bus.req_op[0] = mk(3'b000, 7'h20, 1'b1, 32'd10, 32'd99, 32'd3);
        bus.req_tag[0] = 4'h5;
        do_op(0, 2'b01, 32'd13, 4'h5, "addi_f7");
        bus.req_op[0] = mk(3'b011, 7'h00, 1'b1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        bus.req_tag[0] = 4'h6;
        do_op(0, 2'b01, 32'd1, 4'h6, "sltiu");
        bus.req_op[0] = mk(3'b010, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        bus.req_tag[0] = 4'h7;
        do_op(0, 2'b01, 32'd1, 4'h7, "slt");
        bus.req_op[0] = mk(3'b011, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        bus.req_tag[0] = 4'h8;
        do_op(0, 2'b01, 32'd0, 4'h8, "sltu");
        bus.req_valid = '0;

        // Contention: both requesters valid throughout, order 0,1,0,1.
        do_reset();
        bus.req_op[0] = mk(3'b000, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0);
        bus.req_tag[0] = 4'h1;
        bus.req_op[1] = mk(3'b000, 7'h20, 1'b0, 32'd3, 32'd5, 32'd0);
        bus.req_tag[1] = 4'h2;
        do_op(0, 2'b11, 32'd12, 4'h1, "rr0");
        do_op(1, 2'b11, 32'hFFFF_FFFE, 4'h2, "rr1");
        do_op(0, 2'b11, 32'd12, 4'h1, "rr2");
        do_op(1, 2'b11, 32'hFFFF_FFFE, 4'h2, "rr3");
        bus.req_valid = '0;

        // Backpressure: srai held for 5 cycles; req1 waits, its resp_ready ignored.
        bus.req_op[0] = mk(3'b101, 7'h20, 1'b1, 32'h8000_0000, 32'd0, 32'd4);
        bus.req_tag[0] = 4'h9;
        bus.resp_ready = 2'b10;
        @(negedge clock);
        bus.req_valid = 2'b01;
        #1;
        chk("bp.grant", bus.req_ready, 2'b01);
        @(negedge clock);
        bus.req_valid = 2'b11;
        #1;
        chk("bp.exec_busy", busy, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            chk("bp.resp_valid",  bus.resp_valid, 2'b01);
            chk("bp.resp_result", bus.resp_result, 32'hF800_0000);
            chk("bp.resp_tag",    bus.resp_tag, 4'h9);
            chk("bp.busy",        busy, 1);
            chk("bp.req_ready",   bus.req_ready, 0);
        end
        $display("txn srai: req0 tag 0x%0h result 0x%08h", bus.resp_tag, bus.resp_result);
        bus.resp_ready = 2'b11;
        @(negedge clock);
        #1;
        chk("bp.idle_busy",  busy, 0);
        chk("bp.next_grant", bus.req_ready, 2'b10);
        bus.req_valid = '0;

        // Reset during EXEC discards the op; requester 0 wins afterwards.
        bus.req_op[1] = mk(3'b000, 7'h00, 1'b0, 32'd1, 32'd1, 32'd0);
        bus.req_tag[1] = 4'h4;
        @(negedge clock);
        bus.req_valid = 2'b10;
        #1;
        chk("rx.grant", bus.req_ready, 2'b10);
        @(negedge clock);
        #1;
        chk("rx.exec_busy", busy, 1);
        reset_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("rx.in_rst_ready", bus.req_ready, 0);
        chk("rx.in_rst_busy",  busy, 0);
        @(negedge clock);
        #1;
        chk("rx.busy",        busy, 0);
        chk("rx.resp_valid",  bus.resp_valid, 0);
        chk("rx.resp_result", bus.resp_result, 0);
        chk("rx.resp_tag",    bus.resp_tag, 0);
        reset_n = 1'b1;
        bus.req_valid = '0;
        bus.req_op[0] = mk(3'b110, 7'h00, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'd0);
        bus.req_tag[0] = 4'hA;
        do_op(0, 2'b11, 32'h0000_00FF, 4'hA, "post_rst");
        bus.req_valid = '0;

`ifdef ALU_ARB_LOCK_EN
        // Lock: req1 keeps the ALU for three ops although req0 is waiting.
        do_reset();
        bus.req_op[0] = mk(3'b000, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0);
        bus.req_tag[0] = 4'h1;
        bus.req_op[1] = mk(3'b100, 7'h00, 1'b0, 32'h0000_FFFF, 32'h0000_00FF, 32'd0);
        bus.req_tag[1] = 4'hB;
        bus.req_lock = 2'b10;
        do_op(1, 2'b10, 32'h0000_FF00, 4'hB, "lk1");
        do_op(1, 2'b11, 32'h0000_FF00, 4'hB, "lk2");
        chk("lk.owner_valid", bus.lock_owner_valid, 1);
        do_op(1, 2'b11, 32'h0000_FF00, 4'hB, "lk3");
        bus.req_lock = 2'b00;
        do_op(0, 2'b11, 32'd12, 4'h1, "lk_rel");
        chk("lk.owner_released", bus.lock_owner_valid, 0);
        bus.req_valid = '0;
`endif

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
